// File: rtl/pov_pkg.sv
// pov_pkg: shared definitions for the POV LED-arm output path.
//   - default WS2812 timing constants for a 50 MHz clock
//   - transmitter state encoding
//   - RGB -> GRB reorder (WS2812 expects green first on the wire)
package pov_pkg;

  localparam int N_LEDS_DEF = 52;
  localparam int T0H_DEF    = 20;     // 400 ns high for a 0 bit
  localparam int T1H_DEF    = 40;     // 800 ns high for a 1 bit
  localparam int TBIT_DEF   = 63;     // 1.26 us bit period
  localparam int TRST_DEF   = 15000;  // 300 us latch gap

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_LATCH = 2'd2
  } tx_state_e;

  function automatic logic [23:0] rgb_to_grb(input logic [23:0] rgb);
    return {rgb[15:8], rgb[23:16], rgb[7:0]};
  endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// ws2812_bit_timer: per-bit NRZ pulse generator and shared cycle counter.
//   clk, reset       : clock, async active-low reset
//   send, latch      : current phase of the transmitter (SEND / LATCH)
//   send_nxt         : transmitter will be in SEND next cycle
//   bit_val_nxt      : bit that will be on the wire next cycle
//   led_data         : registered serial output
//   bit_end          : last cycle of the current bit (SEND only)
//   gap_end          : last cycle of the latch gap (LATCH only)
//   cyc_cnt_nxt      : next value of the cycle counter
module ws2812_bit_timer
  import pov_pkg::*;
#(
  parameter int T0H_CYC  = T0H_DEF,
  parameter int T1H_CYC  = T1H_DEF,
  parameter int TBIT_CYC = TBIT_DEF,
  parameter int TRST_CYC = TRST_DEF,
  parameter int CNT_W    = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             send,
  input  logic             latch,
  input  logic             send_nxt,
  input  logic             bit_val_nxt,
  output logic             led_data,
  output logic             bit_end,
  output logic             gap_end,
  output logic [CNT_W-1:0] cyc_cnt_nxt
);

  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [CNT_W-1:0] th;
  logic             led_data_q, led_data_d;

  always_comb begin
    bit_end    = send  && (cyc_cnt_q == CNT_W'(TBIT_CYC - 1));
    gap_end    = latch && (cyc_cnt_q == CNT_W'(TRST_CYC - 1));
    // Counter restarts at every bit boundary, at the phase change and in IDLE,
    // so each new bit or gap always begins at 0 without a dedicated start input.
    cyc_cnt_d  = '0;
    if ((send && !bit_end) || (latch && !gap_end)) begin
      cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
    end
    th         = bit_val_nxt ? CNT_W'(T1H_CYC) : CNT_W'(T0H_CYC);
    // The output is registered, so it is computed from next-cycle values;
    // this puts the first high cycle directly after the frame-start edge.
    led_data_d = send_nxt && (cyc_cnt_d < th);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_cnt_q  <= '0;
      led_data_q <= 1'b0;
    end else begin
      cyc_cnt_q  <= cyc_cnt_d;
      led_data_q <= led_data_d;
    end
  end

  assign led_data    = led_data_q;
  assign cyc_cnt_nxt = cyc_cnt_d;

endmodule

// File: rtl/ws2812_column_tx.sv
// ws2812_column_tx: drives one WS2812 strip with a single colour per frame.
// A frame snapshots pixel_color (reordered to GRB), sends it to every LED,
// then holds the line low for the latch gap. Frames repeat while enabled.
//   clk          : system clock
//   reset        : async active-low reset
//   enable       : allows frames to start (a running frame always completes)
//   pixel_color  : RGB colour, R=[23:16] G=[15:8] B=[7:0]
//   led_data     : registered serial line to the strip
//   busy         : high during SEND and LATCH
//   frame_done   : one-cycle pulse on the last cycle of the latch gap
module ws2812_column_tx
  import pov_pkg::*;
#(
  parameter int N_LEDS   = N_LEDS_DEF,
  parameter int T0H_CYC  = T0H_DEF,
  parameter int T1H_CYC  = T1H_DEF,
  parameter int TBIT_CYC = TBIT_DEF,
  parameter int TRST_CYC = TRST_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [23:0] pixel_color,
  output logic        led_data,
  output logic        busy,
  output logic        frame_done
);

  localparam int CNT_MAX = (TBIT_CYC > TRST_CYC) ? TBIT_CYC : TRST_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int LED_W   = $clog2(N_LEDS) + 1;

  tx_state_e        state_q, state_d;
  logic [23:0]      color_q, color_d;
  logic [23:0]      shift_q, shift_d;
  logic [4:0]       bit_idx_q, bit_idx_d;
  logic [LED_W-1:0] led_idx_q, led_idx_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;

  logic             start_frame;
  logic [23:0]      snap_grb;
  logic             bit_end, gap_end;
  logic [CNT_W-1:0] cyc_cnt_nxt;

  assign snap_grb = rgb_to_grb(pixel_color);

  always_comb begin
    state_d     = state_q;
    color_d     = color_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    led_idx_d   = led_idx_q;
    start_frame = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        bit_idx_d = '0;
        led_idx_d = '0;
        if (enable) start_frame = 1'b1;
      end
      ST_SEND: begin
        if (bit_end) begin
          if (bit_idx_q == 5'd23) begin
            // Next LED gets the same colour: reload with no extra cycle.
            bit_idx_d = '0;
            shift_d   = color_q;
            led_idx_d = led_idx_q + LED_W'(1);
            if (led_idx_q == LED_W'(N_LEDS - 1)) state_d = ST_LATCH;
          end else begin
            shift_d   = {shift_q[22:0], 1'b0};
            bit_idx_d = bit_idx_q + 5'd1;
          end
        end
      end
      ST_LATCH: begin
        if (gap_end) begin
          if (enable) start_frame = 1'b1;
          else        state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_frame) begin
      state_d   = ST_SEND;
      color_d   = snap_grb;
      shift_d   = snap_grb;
      bit_idx_d = '0;
      led_idx_d = '0;
    end

    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state_d == ST_LATCH) && (cyc_cnt_nxt == CNT_W'(TRST_CYC - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      color_q      <= '0;
      shift_q      <= '0;
      bit_idx_q    <= '0;
      led_idx_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      color_q      <= color_d;
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      led_idx_q    <= led_idx_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  ws2812_bit_timer #(
    .T0H_CYC  (T0H_CYC),
    .T1H_CYC  (T1H_CYC),
    .TBIT_CYC (TBIT_CYC),
    .TRST_CYC (TRST_CYC),
    .CNT_W    (CNT_W)
  ) u_bit_timer (
    .clk         (clk),
    .reset       (reset),
    .send        (state_q == ST_SEND),
    .latch       (state_q == ST_LATCH),
    .send_nxt    (state_d == ST_SEND),
    .bit_val_nxt (shift_d[23]),
    .led_data    (led_data),
    .bit_end     (bit_end),
    .gap_end     (gap_end),
    .cyc_cnt_nxt (cyc_cnt_nxt)
  );

  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ws2812_column_tx.sv
// Testbench for ws2812_column_tx with small timing parameters.
// Expected waveforms come from a cycle-index model of the NRZ protocol.
module tb_ws2812_column_tx;

  localparam int N_LEDS   = 2;
  localparam int T0H      = 2;
  localparam int T1H      = 4;
  localparam int TBIT     = 6;
  localparam int TRST     = 10;
  localparam int SEND_CYC = N_LEDS * 24 * TBIT;  // 288
  localparam int FRAME    = SEND_CYC + TRST;     // 298

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [23:0] pixel_color;
  logic        led_data;
  logic        busy;
  logic        frame_done;

  int n_checks = 0;
  int n_errors = 0;

  ws2812_column_tx #(
    .N_LEDS   (N_LEDS),
    .T0H_CYC  (T0H),
    .T1H_CYC  (T1H),
    .TBIT_CYC (TBIT),
    .TRST_CYC (TRST)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .pixel_color (pixel_color),
    .led_data    (led_data),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wire order is G, R, B, MSB first; all LEDs get the same colour.
  function automatic logic [23:0] wire_word(input logic [23:0] rgb);
    return {rgb[15:8], rgb[23:16], rgb[7:0]};
  endfunction

  // Expected led_data at frame cycle k (cycle 0 = first cycle after start edge).
  function automatic logic exp_led(input logic [23:0] rgb, input int k);
    logic [23:0] w;
    int          b;
    logic        bv;
    if (k >= SEND_CYC) return 1'b0;
    w  = wire_word(rgb);
    b  = (k / TBIT) % 24;
    bv = w[23 - b];
    return (k % TBIT) < (bv ? T1H : T0H);
  endfunction

  // Checks a whole frame starting at cycle 0. Optionally changes pixel_color
  // after cycle chg_at and drops enable after cycle drop_at (-1 = never).
  task automatic check_frame(input string name, input logic [23:0] exp_rgb,
                             input int chg_at, input logic [23:0] chg_color,
                             input int drop_at);
    int          hi_cnt[N_LEDS*24];
    int          busy_cycles;
    int          fd_at;
    logic [47:0] decoded;
    logic [47:0] want;
    logic        e_led, e_fd;
    for (int i = 0; i < N_LEDS*24; i++) hi_cnt[i] = 0;
    busy_cycles = 0;
    fd_at       = -1;
    for (int k = 0; k < FRAME; k++) begin
      e_led = exp_led(exp_rgb, k);
      e_fd  = (k == FRAME - 1);
      n_checks++;
      if ({led_data, busy, frame_done} !== {e_led, 1'b1, e_fd}) begin
        n_errors++;
        $display("FAIL %s cycle %0d: led/busy/done=%b%b%b expected %b%b%b",
                 name, k, led_data, busy, frame_done, e_led, 1'b1, e_fd);
      end
      if (k < SEND_CYC && led_data === 1'b1) hi_cnt[k / TBIT]++;
      if (busy === 1'b1) busy_cycles++;
      if (frame_done === 1'b1 && fd_at < 0) fd_at = k;
      if (k == chg_at) pixel_color = chg_color;
      if (k == drop_at) enable = 1'b0;
      tick();
    end
    for (int i = 0; i < N_LEDS*24; i++) decoded[47 - i] = (hi_cnt[i] >= 3);
    want = {wire_word(exp_rgb), wire_word(exp_rgb)};
    n_checks++;
    if (decoded !== want) begin
      n_errors++;
      $display("FAIL %s decoded bits: got %h expected %h", name, decoded, want);
    end
    n_checks++;
    if (busy_cycles != FRAME || fd_at != FRAME - 1) begin
      n_errors++;
      $display("FAIL %s frame timing: busy cycles %0d done at %0d, expected %0d and %0d",
               name, busy_cycles, fd_at, FRAME, FRAME - 1);
    end
    if (!enable) begin
      n_checks++;
      if ({led_data, busy, frame_done} !== 3'b000) begin
        n_errors++;
        $display("FAIL %s idle after frame: led/busy/done=%b%b%b expected 000",
                 name, led_data, busy, frame_done);
      end
    end
  endtask

  task automatic test_reset();
    reset       = 1'b0;
    enable      = 1'b1;
    pixel_color = 24'hFFFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({led_data, busy, frame_done} !== 3'b000) begin
        n_errors++;
        $display("FAIL reset_hold: led/busy/done=%b%b%b expected 000", led_data, busy, frame_done);
      end
    end
    enable = 1'b0;
    reset  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({led_data, busy, frame_done} !== 3'b000) begin
        n_errors++;
        $display("FAIL idle_disabled: led/busy/done=%b%b%b expected 000", led_data, busy, frame_done);
      end
    end
  endtask

  task automatic test_single(input string name, input logic [23:0] rgb);
    pixel_color = rgb;
    enable      = 1'b1;
    tick();
    check_frame(name, rgb, -1, 24'h0, 0);
  endtask

  task automatic test_color_change();
    pixel_color = 24'hFF0000;
    enable      = 1'b1;
    tick();
    check_frame("chg_first", 24'hFF0000, 50, 24'h00FF00, -1);
    check_frame("chg_second", 24'h00FF00, -1, 24'h0, 0);
  endtask

  task automatic test_enable_drop();
    logic [23:0] c;
    c           = 24'($urandom);
    pixel_color = c;
    enable      = 1'b1;
    tick();
    check_frame("enable_drop", c, -1, 24'h0, 100);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if ({led_data, busy, frame_done} !== 3'b000) begin
        n_errors++;
        $display("FAIL enable_drop_idle: led/busy/done=%b%b%b expected 000", led_data, busy, frame_done);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [23:0] c;
    pixel_color = 24'hFF0000;
    enable      = 1'b1;
    tick();
    repeat (37) tick();
    n_checks++;
    if (led_data !== exp_led(24'hFF0000, 37) || led_data !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_mid_pre: led=%b expected 1", led_data);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({led_data, busy, frame_done} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_mid_async: led/busy/done=%b%b%b expected 000", led_data, busy, frame_done);
    end
    tick();
    n_checks++;
    if ({led_data, busy, frame_done} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_mid_hold: led/busy/done=%b%b%b expected 000", led_data, busy, frame_done);
    end
    c           = 24'($urandom);
    pixel_color = c;
    reset       = 1'b1;
    tick();
    check_frame("after_reset", c, -1, 24'h0, 0);
  endtask

  task automatic test_back_to_back();
    logic [23:0] cur, nxt;
    int          chg;
    cur         = 24'($urandom);
    pixel_color = cur;
    enable      = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      nxt = 24'($urandom);
      chg = int'($urandom_range(0, FRAME - 1));
      check_frame("back_to_back", cur, chg, nxt, (i == 3) ? FRAME - 1 : -1);
      cur = nxt;
    end
  endtask

  initial begin
    test_reset();
    test_single("red", 24'hFF0000);
    test_single("mixed", 24'h00A5C3);
    test_single("zero", 24'h000000);
    test_single("white", 24'hFFFFFF);
    test_color_change();
    test_enable_drop();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
